// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with write bypass, per-register
// busy scoreboard for in-flight writebacks, optional registered reads and
// sticky address-error flags.

// Per-port lookup: resolves one read address against the array, the busy
// bits and a same-cycle writeback (bypass). Purely combinational.
module regfile_sb_rdport #(
  parameter int N_REGS   = 32,
  parameter int R_WIDTH  = 32,
  parameter int W_ADDR   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [W_ADDR-1:0]               addr,
  input  logic                            wr_ok,
  input  logic [W_ADDR-1:0]               wr_addr,
  input  logic [R_WIDTH-1:0]              wr_data,
  input  logic [N_REGS-1:0][R_WIDTH-1:0]  regs,
  input  logic [N_REGS-1:0]               busy,
  output logic [R_WIDTH-1:0]              data,
  output logic                            stale,
  output logic                            oor
);
  typedef struct packed {
    logic [R_WIDTH-1:0] data;
    logic               busy;
  } rsp_t;

  rsp_t rsp;

  assign oor = !(32'(addr) < N_REGS);

  // Priority: hardwired zero, out of range, bypass, then array contents.
  always_comb begin
    rsp = '0;
    if (ZERO_REG != 0 && addr == '0) begin
      rsp = '0;
    end else if (oor) begin
      rsp = '0;
    end else if (wr_ok && wr_addr == addr) begin
      rsp.data = wr_data;
      rsp.busy = 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (addr == W_ADDR'(i)) begin
          rsp.data = regs[i];
          rsp.busy = busy[i];
        end
      end
    end
  end

  assign data  = rsp.data;
  assign stale = rsp.busy;
endmodule

module regfile_sb #(
  parameter  int N_REGS   = 32,
  parameter  int R_WIDTH  = 32,
  parameter  int N_RD     = 2,
  parameter  int ZERO_REG = 1,
  parameter  int READ_REG = 0,
  localparam int W_ADDR   = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int CW       = $clog2(N_REGS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [W_ADDR-1:0]         wr_addr,
  input  logic [R_WIDTH-1:0]        wr_data,
  input  logic                      rsv_en,
  input  logic [W_ADDR-1:0]         rsv_addr,
  input  logic [N_RD-1:0]           rd_en,
  input  logic [N_RD*W_ADDR-1:0]    rd_addr,
  output logic [N_RD*R_WIDTH-1:0]   rd_data,
  output logic [N_RD-1:0]           rd_busy,
  output logic [N_RD-1:0]           rd_valid,
  output logic [CW-1:0]             busy_cnt,
  input  logic                      err_clr,
  output logic                      err_wr,
  output logic                      err_rd
);
  logic [N_REGS-1:0][R_WIDTH-1:0] regs;
  logic [N_REGS-1:0]              busy, busy_nxt;
  logic [CW-1:0]                  cnt_nxt;
  logic                           wr_ok, rsv_ok, wr_oor, rsv_oor;
  logic [N_RD-1:0]                rd_bad;

  function automatic logic in_rng(input logic [W_ADDR-1:0] a);
    return 32'(a) < N_REGS;
  endfunction

  function automatic logic writable(input logic [W_ADDR-1:0] a);
    return in_rng(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign wr_ok   = wr_en  && writable(wr_addr);
  assign rsv_ok  = rsv_en && writable(rsv_addr);
  assign wr_oor  = wr_en  && !in_rng(wr_addr);
  assign rsv_oor = rsv_en && !in_rng(rsv_addr);

  // Register array: only an in-range, writable address is ever updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++)
        if (wr_ok && wr_addr == W_ADDR'(i)) regs[i] <= wr_data;
    end
  end

  // Next busy vector: writeback clears, reserve sets; reserve applied last so
  // a new producer supersedes the one completing in the same cycle.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (wr_ok  && wr_addr  == W_ADDR'(i)) busy_nxt[i] = 1'b0;
      if (rsv_ok && rsv_addr == W_ADDR'(i)) busy_nxt[i] = 1'b1;
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end
  end

  // Scoreboard and its population count move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Sticky error flags; a new set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_wr <= 1'b0;
      err_rd <= 1'b0;
    end else begin
      err_wr <= (wr_oor || rsv_oor) || (err_wr && !err_clr);
      err_rd <= (|rd_bad) || (err_rd && !err_clr);
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic [R_WIDTH-1:0] lk_data;
    logic               lk_busy, lk_oor;

    regfile_sb_rdport #(
      .N_REGS   (N_REGS),
      .R_WIDTH  (R_WIDTH),
      .W_ADDR   (W_ADDR),
      .ZERO_REG (ZERO_REG)
    ) u_lk (
      .addr    (rd_addr[p*W_ADDR +: W_ADDR]),
      .wr_ok   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .regs    (regs),
      .busy    (busy),
      .data    (lk_data),
      .stale   (lk_busy),
      .oor     (lk_oor)
    );

    assign rd_bad[p] = rd_en[p] && lk_oor;

    if (READ_REG != 0) begin : g_q
      logic [R_WIDTH-1:0] q_data;
      logic               q_busy, q_vld;

      // Capture the lookup on the edge ending the rd_en cycle; hold otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_data <= '0;
          q_busy <= 1'b0;
          q_vld  <= 1'b0;
        end else begin
          q_vld <= rd_en[p];
          if (rd_en[p]) begin
            q_data <= lk_data;
            q_busy <= lk_busy;
          end
        end
      end

      assign rd_data[p*R_WIDTH +: R_WIDTH] = q_data;
      assign rd_busy[p]                    = q_busy;
      assign rd_valid[p]                   = q_vld;
    end else begin : g_c
      assign rd_data[p*R_WIDTH +: R_WIDTH] = rd_en[p] ? lk_data : '0;
      assign rd_busy[p]                    = rd_en[p] && lk_busy;
      assign rd_valid[p]                   = rd_en[p];
    end
  end
endmodule
